// File: rtl/serial_frame_rx_pkg.sv
// Shared types and defaults for the serial frame receiver.
package serial_frame_rx_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

endpackage

// File: rtl/frame_hold_reg.sv
// Single-entry output holding register with valid/ready handshake and sticky overrun.
module frame_hold_reg
  import serial_frame_rx_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_perr,
  input  logic              ld_ferr,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  input  logic              clr_ovr
);

  logic accept;
  logic can_load;

  assign accept   = dout_valid & dout_ready;
  assign can_load = ~dout_valid | accept;

  // Load a completed frame when there is room, otherwise drop it and flag overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (ld && can_load) begin
        dout       <= ld_data;
        parity_err <= ld_perr;
        frame_err  <= ld_ferr;
        dout_valid <= 1'b1;
      end else if (accept) begin
        dout_valid <= 1'b0;
      end
      // A dropped frame in the same cycle as a clear still leaves overrun set.
      if (ld && !can_load) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Strobed serial frame receiver: start, LSB-first data, optional even parity, stop.
module serial_frame_rx
  import serial_frame_rx_pkg::*;
#(
  parameter int unsigned DATA_W    = DEFAULT_DATA_W,
  parameter int unsigned PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  input  logic              sin_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  input  logic              clr_ovr,
  output logic              busy
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              pbad_q, pbad_d;
  logic              ld_c;
  logic              ld_ferr_c;

  // State, shifter, counter and parity register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      data_q  <= '0;
      pbad_q  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
      pbad_q  <= pbad_d;
      busy    <= (state_d != IDLE);
    end
  end

  // Next-state and datapath updates; nothing moves without a bit strobe.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    data_d    = data_q;
    pbad_d    = pbad_q;
    ld_c      = 1'b0;
    ld_ferr_c = 1'b0;
    if (sin_en) begin
      case (state_q)
        IDLE: begin
          if (!sin) begin
            state_d = DATA;
            count_d = '0;
            pbad_d  = 1'b0;
          end
        end
        DATA: begin
          data_d[count_q] = sin;
          if (count_q == LAST_BIT) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            count_d = CNT_W'(count_q + 1'b1);
          end
        end
        PARITY: begin
          pbad_d  = (^data_q) ^ sin;
          state_d = STOP;
        end
        STOP: begin
          ld_c      = 1'b1;
          ld_ferr_c = ~sin;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  frame_hold_reg #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk        (clk),
    .rst        (rst),
    .ld         (ld_c),
    .ld_data    (data_q),
    .ld_perr    (pbad_q),
    .ld_ferr    (ld_ferr_c),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .clr_ovr    (clr_ovr)
  );

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (DATA_W=8, even parity enabled).
module tb_serial_frame_rx;

  logic       clk;
  logic       rst;
  logic       sin;
  logic       sin_en;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       clr_ovr;
  logic       busy;

  int checks;
  int errors;

  serial_frame_rx #(
    .DATA_W    (8),
    .PARITY_EN (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_en     (sin_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .clr_ovr    (clr_ovr),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One strobed bit, then `gap` idle cycles with sin toggling to prove it is ignored.
  task automatic strobe(input logic b, input int gap);
    sin    = b;
    sin_en = 1'b1;
    @(posedge clk);
    #1;
    sin_en = 1'b0;
    for (int g = 0; g < gap; g++) begin
      sin = ~sin;
      @(posedge clk);
      #1;
    end
  endtask

  // Full frame; returns right after the stop-strobe edge (+1) so the load is visible.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int gap, input logic clr);
    strobe(1'b0, gap);
    for (int i = 0; i < 8; i++) strobe(d[i], gap);
    strobe(par, gap);
    clr_ovr = clr;
    strobe(stp, 0);
    clr_ovr = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    sin        = 1'b1;
    sin_en     = 1'b0;
    dout_ready = 1'b1;
    clr_ovr    = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_valid", 32'(dout_valid), 32'h0);
    check("rst_perr", 32'(parity_err), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Clean frame 0xA5 (4 ones -> parity 0), ready high
    strobe(1'b0, 0);
    check("busy_after_start", 32'(busy), 32'h1);
    for (int i = 0; i < 8; i++) strobe(i[0] ? ((8'hA5 >> i) & 1) != 0 : ((8'hA5 >> i) & 1) != 0, 0);
    strobe(1'b0, 0);
    strobe(1'b1, 0);
    check("a5_valid", 32'(dout_valid), 32'h1);
    check("a5_dout", 32'(dout), 32'hA5);
    check("a5_perr", 32'(parity_err), 32'h0);
    check("a5_ferr", 32'(frame_err), 32'h0);
    check("a5_busy_idle", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    check("a5_valid_pulse", 32'(dout_valid), 32'h0);
    check("a5_dout_hold", 32'(dout), 32'hA5);

    // Bad parity and bad stop
    send_frame(8'hA5, 1'b1, 1'b0, 0, 1'b0);
    check("err_valid", 32'(dout_valid), 32'h1);
    check("err_dout", 32'(dout), 32'hA5);
    check("err_perr", 32'(parity_err), 32'h1);
    check("err_ferr", 32'(frame_err), 32'h1);
    @(posedge clk);
    #1;

    // Overrun: hold 0x3C, drop 0x55
    dout_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b1, 0, 1'b0);
    check("ovr_first_valid", 32'(dout_valid), 32'h1);
    check("ovr_first_dout", 32'(dout), 32'h3C);
    check("ovr_not_yet", 32'(overrun), 32'h0);
    send_frame(8'h55, 1'b0, 1'b1, 0, 1'b0);
    check("ovr_dout_kept", 32'(dout), 32'h3C);
    check("ovr_set", 32'(overrun), 32'h1);
    clr_ovr = 1'b1;
    @(posedge clk);
    #1;
    clr_ovr = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'h0);

    // Clear coinciding with a dropped frame: set wins
    send_frame(8'h12, 1'b0, 1'b1, 0, 1'b1);
    check("ovr_set_wins", 32'(overrun), 32'h1);
    check("ovr_dout_still", 32'(dout), 32'h3C);
    check("ovr_valid_still", 32'(dout_valid), 32'h1);
    clr_ovr = 1'b1;
    @(posedge clk);
    #1;
    clr_ovr = 1'b0;
    check("ovr_cleared2", 32'(overrun), 32'h0);
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    check("drain_valid", 32'(dout_valid), 32'h0);

    // Strobe every 3rd cycle with sin toggling in between; 0x81 (2 ones -> parity 0)
    send_frame(8'h81, 1'b0, 1'b1, 2, 1'b0);
    check("slow_valid", 32'(dout_valid), 32'h1);
    check("slow_dout", 32'(dout), 32'h81);
    check("slow_perr", 32'(parity_err), 32'h0);
    check("slow_ferr", 32'(frame_err), 32'h0);
    @(posedge clk);
    #1;

    // Reset after 4 data bits, then a full 0x0F frame
    strobe(1'b0, 0);
    for (int i = 0; i < 4; i++) strobe(1'b1, 0);
    check("mid_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    sin = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_valid", 32'(dout_valid), 32'h0);
    check("mid_rst_dout", 32'(dout), 32'h0);
    send_frame(8'h0F, 1'b0, 1'b1, 0, 1'b0);
    check("post_rst_valid", 32'(dout_valid), 32'h1);
    check("post_rst_dout", 32'(dout), 32'h0F);
    check("post_rst_perr", 32'(parity_err), 32'h0);
    check("post_rst_ferr", 32'(frame_err), 32'h0);
    check("post_rst_ovr", 32'(overrun), 32'h0);
    @(posedge clk);
    #1;
    check("post_rst_drain", 32'(dout_valid), 32'h0);

    // Idle line: 20 strobes of 1
    for (int i = 0; i < 20; i++) begin
      strobe(1'b1, 0);
      check("idle_busy", 32'(busy), 32'h0);
      check("idle_valid", 32'(dout_valid), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame.
REQ-002 Parameter PARITY_EN, default 1; 1 = even parity bit present after data, 0 = no parity bit.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 sin  input  1  serial data bit from the upstream shift register's serial output.
REQ-006 sin_en  input  1  bit strobe; sin is sampled only in cycles where sin_en=1.
REQ-007 dout  output  DATA_W  assembled frame data.
REQ-008 dout_valid  output  1  dout and its flags hold a frame.
REQ-009 dout_ready  input  1  consumer accepts the frame when dout_valid=1 and dout_ready=1.
REQ-010 parity_err  output  1  flag accompanying dout: parity mismatch.
REQ-011 frame_err  output  1  flag accompanying dout: stop bit sampled as 0.
REQ-012 overrun  output  1  sticky: a completed frame was dropped.
REQ-013 clr_ovr  input  1  clears overrun.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 Frame format: start bit (0), then DATA_W data bits (LSB first), then the parity bit if PARITY_EN=1, then the stop bit (1); each bit is consumed on one sin_en cycle.
REQ-016 The FSM SHALL have the states IDLE, DATA, PARITY and STOP, and SHALL remain in its current state in any cycle with sin_en=0.
REQ-017 IDLE: when sin_en=1 and sin=0, the FSM SHALL go to DATA with the bit counter at 0; when sin_en=1 and sin=1, it SHALL stay in IDLE.
REQ-018 DATA: on each strobe the FSM SHALL shift sin into bit position [count] and increment the counter; after the strobe at count=DATA_W-1 it SHALL go to PARITY (PARITY_EN=1) or STOP (PARITY_EN=0).
REQ-019 PARITY: on the strobe the block SHALL record parity_bad = (XOR of the data bits) XOR sin, and then go to STOP.
REQ-020 STOP: on the strobe the block SHALL record stop_bad = ~sin, complete the frame, and return to IDLE; a new start bit is accepted from the next strobe.
REQ-021 At frame completion, if the holding register is empty, or is being accepted in the same cycle, the frame SHALL load into dout/parity_err/frame_err with dout_valid=1 in the next cycle (1-cycle latency from the stop strobe).
REQ-022 At frame completion, if the holding register is full and not being accepted, the new frame SHALL be dropped, the held frame SHALL be kept unchanged, and overrun SHALL be set.
REQ-023 Frames with errors SHALL still be delivered, with their flags set; the flags are valid only while dout_valid=1.
REQ-024 On a handshake (dout_valid & dout_ready) with no simultaneous load, dout_valid SHALL clear in the next cycle; dout SHALL hold its value.
REQ-025 dout, parity_err and frame_err SHALL be stable while dout_valid=1 and dout_ready=0.
REQ-026 When clr_ovr and an overrun event occur in the same cycle, overrun SHALL be 1 in the next cycle (set wins).
REQ-027 The bit counter SHALL be $clog2(DATA_W) bits wide with no wrap beyond DATA_W-1.

Reset
REQ-028 While rst=1, at the clock edge: FSM to IDLE, counter 0, dout 0, dout_valid 0, parity_err 0, frame_err 0, overrun 0, busy 0.
REQ-029 Reset mid-frame SHALL abandon the partial frame with no output and no overrun; reset has priority over all inputs.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (IDLE, DATA, PARITY, STOP) and the default DATA_W constant.
REQ-031 The output holding register with its valid/ready and overrun logic SHALL be a sub-module named frame_hold_reg; the FSM and shifter stay in the top module.

Verification
REQ-032 DATA_W=8, PARITY_EN=1, strobe every cycle; bits 0, then 0xA5 LSB first, then parity 0, then stop 1; dout_ready=1 -> dout=0xA5, dout_valid pulses 1 cycle after the stop strobe, both flags 0.
REQ-033 Same frame with parity bit 1 and stop bit 0 -> dout=0xA5, parity_err=1, frame_err=1.
REQ-034 dout_ready=0; send frames 0x3C then 0x55 -> dout stays 0x3C, overrun=1; one clr_ovr pulse -> overrun=0.
REQ-035 Strobe every 3rd cycle, sin toggling between strobes -> only strobe-cycle values captured; frame 0x81 received correctly.
REQ-036 rst=1 after 4 data bits, then a full frame 0x0F -> only 0x0F delivered; no overrun, no error flags.
REQ-037 Idle line sin=1 for 20 strobes -> busy=0 and dout_valid=0 throughout.
